// File: rtl/hazard_track_unit_if.sv
// ID-stage hazard bundle: decoded operand/destination fields in, pipeline
// control, forwarding selects and performance counters out.
interface hazard_track_unit_if #(
  parameter int REG_AW     = 5,
  parameter int MEM_STAGES = 1,
  parameter int CNT_W      = 32
);
  localparam int FW = $clog2(MEM_STAGES + 2);

  logic              branch_id;
  logic              rs1_use_id;
  logic              rs2_use_id;
  logic [1:0]        optype_id;
  logic [REG_AW-1:0] rs1_id;
  logic [REG_AW-1:0] rs2_id;
  logic [REG_AW-1:0] rd_id;

  logic              pc_en_if;
  logic              reg_fd_stall;
  logic              reg_fd_flush;
  logic              reg_de_flush;
  logic [FW-1:0]     fwd_sel_a;
  logic [FW-1:0]     fwd_sel_b;
  logic              fwd_ls;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  // master = pipeline front end, slave = hazard unit
  modport master (
    output branch_id, rs1_use_id, rs2_use_id, optype_id, rs1_id, rs2_id, rd_id,
    input  pc_en_if, reg_fd_stall, reg_fd_flush, reg_de_flush,
           fwd_sel_a, fwd_sel_b, fwd_ls, stall_cnt, flush_cnt
  );
  modport slave (
    input  branch_id, rs1_use_id, rs2_use_id, optype_id, rs1_id, rs2_id, rd_id,
    output pc_en_if, reg_fd_stall, reg_fd_flush, reg_de_flush,
           fwd_sel_a, fwd_sel_b, fwd_ls, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_track_unit.sv
// Data-hazard tracker: follows EXE/MEM destinations, picks forwarding sources,
// raises load-use stalls. Define HAZARD_LS_FWD_EN for load->store forwarding.

module hazard_track_slot_cmp #(
  parameter int REG_AW = 5
) (
  input  logic [1:0]        i_op,
  input  logic [REG_AW-1:0] i_rd,
  input  logic [REG_AW-1:0] i_rs1,
  input  logic [REG_AW-1:0] i_rs2,
  output logic              o_hit_a,
  output logic              o_hit_b,
  output logic              o_load
);
  logic w_writer;

  // x0 is never a producer, so a zero rd can never match
  assign w_writer = ((i_op == 2'b01) || (i_op == 2'b10)) && (i_rd != '0);
  assign o_hit_a  = w_writer && (i_rd == i_rs1);
  assign o_hit_b  = w_writer && (i_rd == i_rs2);
  assign o_load   = (i_op == 2'b10);
endmodule

module hazard_track_unit #(
  parameter int REG_AW     = 5,
  parameter int MEM_STAGES = 1,
  parameter int CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  hazard_track_unit_if.slave  bus
);
  localparam int D  = MEM_STAGES + 1;
  localparam int FW = $clog2(MEM_STAGES + 2);
  localparam logic [1:0] OP_ST = 2'b11;

  typedef struct packed {
    logic [1:0]        op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs2;
  } slot_t;

  slot_t            r_slot [D];
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  slot_t            w_id_slot;
  logic [D-1:0]     w_hit_a, w_hit_b, w_load;
  logic             w_use_a, w_use_b;
  logic             w_fa, w_fb, w_la, w_lb;
  logic [FW-1:0]    w_ka, w_kb;
  logic             w_haz_a, w_haz_b, w_ls_exempt;
  logic             w_stall, w_fd_flush, w_ls_hit;
  logic [FW-1:0]    w_sel_a, w_sel_b;

  assign w_id_slot = '{op: bus.optype_id, rd: bus.rd_id, rs2: bus.rs2_id};
  assign w_use_a   = bus.rs1_use_id && (bus.rs1_id != '0);
  assign w_use_b   = bus.rs2_use_id && (bus.rs2_id != '0);

  generate
    for (genvar k = 0; k < D; k++) begin : g_cmp
      hazard_track_slot_cmp #(.REG_AW(REG_AW)) u_cmp (
        .i_op   (r_slot[k].op),
        .i_rd   (r_slot[k].rd),
        .i_rs1  (bus.rs1_id),
        .i_rs2  (bus.rs2_id),
        .o_hit_a(w_hit_a[k]),
        .o_hit_b(w_hit_b[k]),
        .o_load (w_load[k])
      );
    end
  endgenerate

  // Walk oldest to youngest so the youngest matching producer wins
  always_comb begin
    w_fa = 1'b0; w_ka = '0; w_la = 1'b0;
    w_fb = 1'b0; w_kb = '0; w_lb = 1'b0;
    for (int k = D-1; k >= 0; k--) begin
      if (w_use_a && w_hit_a[k]) begin
        w_fa = 1'b1; w_ka = FW'(k); w_la = w_load[k];
      end
      if (w_use_b && w_hit_b[k]) begin
        w_fb = 1'b1; w_kb = FW'(k); w_lb = w_load[k];
      end
    end
  end

  // A load only has data once it reaches the last MEM slot
  assign w_haz_a = w_fa && w_la && (w_ka < FW'(MEM_STAGES));
  assign w_haz_b = w_fb && w_lb && (w_kb < FW'(MEM_STAGES));
  assign w_sel_a = (w_fa && (!w_la || (w_ka == FW'(MEM_STAGES)))) ? w_ka + 1'b1 : '0;
  assign w_sel_b = (w_fb && (!w_lb || (w_kb == FW'(MEM_STAGES)))) ? w_kb + 1'b1 : '0;

  assign w_ls_hit = (r_slot[MEM_STAGES-1].op == OP_ST) && (r_slot[MEM_STAGES].op == 2'b10) &&
                    (r_slot[MEM_STAGES-1].rs2 == r_slot[MEM_STAGES].rd) &&
                    (r_slot[MEM_STAGES].rd != '0);

`ifdef HAZARD_LS_FWD_EN
  // Store data picks up the load result later through fwd_ls
  assign w_ls_exempt = (bus.optype_id == OP_ST) && (w_kb == '0);
  assign bus.fwd_ls  = !rst && w_ls_hit;
`else
  logic w_unused_ls;
  assign w_unused_ls = w_ls_hit;
  assign w_ls_exempt = 1'b0;
  assign bus.fwd_ls  = 1'b0;
`endif

  assign w_stall    = !rst && (w_haz_a || (w_haz_b && !w_ls_exempt));
  assign w_fd_flush = !rst && bus.branch_id && !w_stall;

  assign bus.pc_en_if     = !w_stall;
  assign bus.reg_fd_stall = w_stall;
  assign bus.reg_de_flush = w_stall;
  assign bus.reg_fd_flush = w_fd_flush;
  assign bus.fwd_sel_a    = rst ? '0 : w_sel_a;
  assign bus.fwd_sel_b    = rst ? '0 : w_sel_b;
  assign bus.stall_cnt    = r_stall_cnt;
  assign bus.flush_cnt    = r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < D; k++) r_slot[k] <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_slot[0] <= w_stall ? slot_t'('0) : w_id_slot;
      for (int k = 1; k < D; k++) r_slot[k] <= r_slot[k-1];
      if (w_stall && (r_stall_cnt != '1))    r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_fd_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end
endmodule

// File: doc/hazard_track_unit.md
HAZARD_TRACK_UNIT -- requirements
Module: hazard_track_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter MEM_STAGES, default 1, range 1..3, number of memory pipeline stages; tracked depth D = MEM_STAGES+1 slots (slot0 = EXE, slot k = MEM stage k).
REQ-003 SHALL have parameter CNT_W, default 32, performance-counter width.
REQ-004 SHALL define local FW = clog2(MEM_STAGES+2), the forward-select width.
REQ-005 SHALL have ports: clk input 1 clock; rst input 1 reset, synchronous active-high (one clock; reset is synchronous and active-high).
REQ-006 SHALL have ports: branch_id input 1 branch taken in ID; rs1_use_id, rs2_use_id input 1 each, operand used.
REQ-007 SHALL have ports: optype_id input 2 (00 none, 01 ALU write, 10 load, 11 store); rs1_id, rs2_id, rd_id input REG_AW each.
REQ-008 SHALL have ports: pc_en_if, reg_fd_stall, reg_fd_flush, reg_de_flush output 1 each.
REQ-009 SHALL have ports: fwd_sel_a, fwd_sel_b output FW each; fwd_ls output 1.
REQ-010 SHALL have ports: stall_cnt, flush_cnt output CNT_W each.

Function
REQ-011 SHALL keep a D-slot tracker holding {optype, rd, rs2} per slot; each clk slot0 <= ID fields, or bubble (optype 00) when reg_de_flush; slot k <= slot k-1.
REQ-012 SHALL treat only optype 01/10 with rd != 0 as writers; register x0 never matches.
REQ-013 SHALL, per operand rsX with rsX_use_id=1 and rsX != 0, find the youngest (lowest-index) writer slot k with rd == rsX.
REQ-014 SHALL drive fwd_sel_X = k+1 for a matching ALU at any k or a load at k = MEM_STAGES; 0 when there is no match or the operand is unused.
REQ-015 SHALL raise stall when the youngest match for either operand is a load in slot k < MEM_STAGES; an older match behind a younger ALU match SHALL NOT stall.
REQ-016 SHALL, during stall, drive pc_en_if=0, reg_fd_stall=1, reg_de_flush=1; otherwise pc_en_if=1, reg_fd_stall=0, reg_de_flush=0.
REQ-017 SHALL drive reg_fd_flush = branch_id & ~stall; stall has priority over branch flush in the same cycle.
REQ-018 SHALL assert fwd_ls when slot MEM_STAGES-1 is a store, slot MEM_STAGES is a load, store rs2 == load rd, and rd != 0.
REQ-019 SHALL increment stall_cnt on each stall cycle and flush_cnt on each reg_fd_flush cycle, both saturating at all-ones (no wrap).
REQ-020 SHALL produce all forwarding, stall and flush outputs combinationally in the same cycle as the ID inputs (zero latency).

Reset
REQ-021 SHALL, on rst high at a clk edge, clear all slots to optype 00, rd 0, rs2 0, and clear both counters to 0.
REQ-022 SHALL, while rst is high, force pc_en_if=1, reg_fd_stall=0, reg_fd_flush=0, reg_de_flush=0, fwd_sel_a/b=0, fwd_ls=0.
REQ-023 SHALL discard in-flight tracking when rst is asserted mid-stall; the first cycle after reset has no stall.

Configuration
REQ-024 SHALL, with macro HAZARD_LS_FWD_EN defined, exempt a store in ID from stalling when its only hazard is rs2 matching a load in slot0; the rs1 hazard still stalls.
REQ-025 SHALL, without HAZARD_LS_FWD_EN, stall that case per REQ-015 and tie fwd_ls to 0.

Verification
REQ-026 SHALL cover: MEM_STAGES=1, ALU rd=5 in slot0, ID rs1=5 used -> fwd_sel_a=1, no stall.
REQ-027 SHALL cover: MEM_STAGES=2, load rd=7 in slot0, ID rs2=7 used -> stall for 2 cycles, then fwd_sel_b=3, stall_cnt=2.
REQ-028 SHALL cover: ALU rd=3 in slot0 and load rd=3 in slot1 (MEM_STAGES=2), ID rs1=3 -> fwd_sel_a=1, no stall.
REQ-029 SHALL cover: load-use stall together with branch_id=1 -> reg_fd_flush=0, reg_de_flush=1, flush_cnt unchanged.
REQ-030 SHALL cover: with HAZARD_LS_FWD_EN and MEM_STAGES=1, load rd=9 then store rs2=9 -> no stall, fwd_ls=1 one cycle later; without the macro -> one stall cycle, fwd_ls=0.
REQ-031 SHALL cover: rst asserted mid-stall -> all outputs at reset values next cycle; counters preset near all-ones saturate and do not wrap.
